// File: rtl/fifo_serial_tx.sv
// Purpose: pops words from a synchronous FIFO and sends them on a UART-style line.
// Latency: tx goes low 3 cycles after a start condition is seen in IDLE.
// Backpressure: one word is popped per frame; a new pop waits for IDLE with tx_en set and the FIFO not empty.
module fifo_serial_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  input  logic                  tx_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  // frame_done is registered, so it is raised one cycle before the last stop cycle
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic              PAR_ON    = (PARITY_EN != 0);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  logic [BAUD_W-1:0]     baud;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic                  parity;
  logic                  baud_end;

  assign shift_nxt = shift >> 1;
  assign baud_end  = (baud == BAUD_LAST);

  // Frame sequencer; every output is registered with the value of the state being entered
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state       <= IDLE;
      baud        <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      parity      <= 1'b0;
      tx          <= 1'b1;
      fifo_rd_en  <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      fifo_rd_en <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_en && !fifo_empty) begin
            state      <= POP;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        POP: begin
          // read data appears on fifo_data_out during LOAD
          state <= LOAD;
        end
        LOAD: begin
          shift  <= fifo_data_out;
          parity <= (^fifo_data_out) ^ PAR_ODD;
          baud   <= '0;
          tx     <= 1'b0;
          state  <= START;
        end
        START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_cnt <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud  <= '0;
            shift <= shift_nxt;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (PAR_ON) begin
                tx    <= parity;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift_nxt[0];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        PARITY: begin
          if (baud_end) begin
            baud  <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud == BAUD_PRE) begin
            frame_done <= 1'b1;
          end
          if (baud_end) begin
            baud        <= '0;
            busy        <= 1'b0;
            frame_count <= frame_count + 16'd1;
            state       <= IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: FIFO model in front, serial receiver/recorder behind,
// scoreboard of expected frames, plus two parity-enabled instances.
module tb_fifo_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_en;
  logic       fifo_empty;
  logic [7:0] fifo_data_out;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic [15:0] frame_count;

  // parity instances share reset and tx_en, read a constant 0xA5
  logic        par_go = 1'b0;
  logic        par_popped = 1'b0;
  logic        par_empty;
  logic [7:0]  par_data;
  logic        pe_rd_en, pe_tx, pe_busy, pe_fd;
  logic [15:0] pe_fc;
  logic        po_rd_en, po_tx, po_busy, po_fd;
  logic [15:0] po_fc;

  always #5 clk = ~clk;

  fifo_serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
    .fifo_rd_en(fifo_rd_en), .tx_en(tx_en), .tx(tx), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count));

  fifo_serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_pe (
    .clk(clk), .rst_n(rst_n), .fifo_empty(par_empty), .fifo_data_out(par_data),
    .fifo_rd_en(pe_rd_en), .tx_en(tx_en), .tx(pe_tx), .busy(pe_busy),
    .frame_done(pe_fd), .frame_count(pe_fc));

  fifo_serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_po (
    .clk(clk), .rst_n(rst_n), .fifo_empty(par_empty), .fifo_data_out(par_data),
    .fifo_rd_en(po_rd_en), .tx_en(tx_en), .tx(po_tx), .busy(po_busy),
    .frame_done(po_fd), .frame_count(po_fc));

  assign par_data  = 8'hA5;
  assign par_empty = !par_go || par_popped;

  always @(posedge clk) begin
    if (pe_rd_en || po_rd_en) par_popped <= 1'b1;
  end

  // FIFO model: data valid the cycle after rd_en is sampled
  logic [7:0] mem [64];
  int push_cnt = 0;
  int pop_cnt  = 0;
  assign fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data_out <= mem[pop_cnt % 64];
      pop_cnt       <= pop_cnt + 1;
    end
  end

  // Recorder: samples each bit mid-cell, logs rd_en, frame_done and start cycles
  int         cyc = 0;
  int         rd_n = 0, done_n = 0, start_n = 0, rx_n = 0;
  int         rd_cyc [64];
  int         done_cyc [64];
  int         start_cyc [64];
  logic [9:0] rx_frame [64];
  logic       mon_on = 1'b0;
  int         mon_t = 0;
  logic [9:0] sh = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (fifo_rd_en === 1'b1) begin rd_cyc[rd_n % 64] = cyc; rd_n = rd_n + 1; end
    if (frame_done === 1'b1) begin done_cyc[done_n % 64] = cyc; done_n = done_n + 1; end
    if (mon_on && busy !== 1'b1) begin
      mon_on = 1'b0;
    end else if (mon_on) begin
      mon_t = mon_t + 1;
    end else if (tx === 1'b0) begin
      mon_on = 1'b1;
      mon_t  = 0;
      start_cyc[start_n % 64] = cyc;
      start_n = start_n + 1;
    end
    if (mon_on && (mon_t % 4) == 2) begin
      sh = {tx, sh[9:1]};
      if (mon_t == 38) begin
        rx_frame[rx_n % 64] = sh;
        rx_n   = rx_n + 1;
        mon_on = 1'b0;
      end
    end
  end

  int tests = 0;
  int fails = 0;
  logic [9:0] exp_q [$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // {stop, data, start} as seen LSB-first on the line
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [9:0] f, input bit expect_frame);
    mem[push_cnt % 64] = d;
    push_cnt = push_cnt + 1;
    if (expect_frame) exp_q.push_back(f);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (rx_n < n && k < budget) begin @(negedge clk); k++; end
    check("wait_frames", (rx_n >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_low(input bit par, input int budget);
    int k = 0;
    while (((par ? pe_tx : tx) !== 1'b0) && k < budget) begin @(negedge clk); k++; end
    check("wait_tx_low", ((par ? pe_tx : tx) === 1'b0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_frame(input string name, input int idx);
    logic [9:0] e;
    e = exp_q.pop_front();
    check(name, {22'd0, rx_frame[idx % 64]}, {22'd0, e});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base, rdb, dnb, fc;
    tbl[0] = '{8'h01, 10'h202};
    tbl[1] = '{8'h02, 10'h204};
    tbl[2] = '{8'h03, 10'h206};
    tbl[3] = '{8'h00, 10'h200};
    tbl[4] = '{8'hFF, 10'h3FE};
    tbl[5] = '{8'h5A, 10'h2B4};

    // reset held with a non-empty FIFO and tx_en high
    rst_n = 1'b1;
    tx_en = 1'b1;
    push(8'hA5, 10'h34A, 1'b1);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_busy", busy, 0);
      check("rst_count", frame_count, 0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("release_pop", fifo_rd_en, 1);

    // single 0xA5 frame
    wait_frames(1, 200);
    repeat (4) @(negedge clk);
    check_frame("a5_frame", 0);
    check("a5_rd_pulses", rd_n, 1);
    check("a5_start_lat", start_cyc[0] - rd_cyc[0], 2);
    check("a5_done_n", done_n, 1);
    check("a5_done_pos", done_cyc[0] - start_cyc[0], 39);
    check("a5_count", frame_count, 1);
    fc = 1;

    // back-to-back batches from the table
    for (int b = 0; b < 2; b++) begin
      base = rx_n;
      rdb  = rd_n;
      for (int i = 0; i < 3; i++) push(tbl[3*b+i].data, tbl[3*b+i].frame, 1'b1);
      wait_frames(base + 3, 600);
      repeat (60) @(negedge clk);
      for (int i = 0; i < 3; i++) check("tbl_frame", {22'd0, rx_frame[(base+i) % 64]}, {22'd0, exp_q.pop_front()});
      for (int i = 0; i < 2; i++) check("tbl_gap", start_cyc[(base+i+1) % 64] - start_cyc[(base+i) % 64], 43);
      check("tbl_rd_pulses", rd_n - rdb, 3);
      fc = fc + 3;
      check("tbl_count", frame_count, fc);
      check("tbl_idle_busy", busy, 0);
    end

    // tx_en dropped during DATA of frame 1 with two words queued
    base = rx_n;
    rdb  = rd_n;
    push(8'h3C, 10'h278, 1'b1);
    push(8'hC3, 10'h386, 1'b1);
    wait_low(1'b0, 20);
    repeat (8) @(negedge clk);
    tx_en = 1'b0;
    repeat (70) @(negedge clk);
    check("gate_frames", rx_n - base, 1);
    check_frame("gate_frame1", base);
    check("gate_rd_pulses", rd_n - rdb, 1);
    check("gate_busy", busy, 0);
    tx_en = 1'b1;
    @(negedge clk);
    check("gate_resume_pop", fifo_rd_en, 1);
    wait_frames(base + 2, 200);
    repeat (4) @(negedge clk);
    check_frame("gate_frame2", base + 1);
    check("gate_start_lat", start_cyc[(start_n-1) % 64] - rd_cyc[(rd_n-1) % 64], 2);
    fc = fc + 2;
    check("gate_count", frame_count, fc);

    // reset during data bit 3; the popped word is discarded
    base = rx_n;
    dnb  = done_n;
    push(8'h96, 10'h000, 1'b0);
    push(8'h69, 10'h2D2, 1'b1);
    wait_low(1'b0, 20);
    repeat (17) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_count", frame_count, 0);
    check("abort_done", frame_done, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_pop", fifo_rd_en, 1);
    wait_frames(base + 1, 200);
    repeat (4) @(negedge clk);
    check_frame("abort_next_frame", base);
    check("abort_done_n", done_n - dnb, 1);
    check("abort_count_after", frame_count, 1);

    // parity on 0xA5: even -> 0, odd -> 1, frame 44 cycles
    par_go = 1'b1;
    wait_low(1'b1, 20);
    check("par_odd_start", po_tx, 0);
    repeat (38) @(negedge clk);
    check("par_even_bit", pe_tx, 0);
    check("par_odd_bit", po_tx, 1);
    check("par_busy", pe_busy, 1);
    repeat (4) @(negedge clk);
    check("par_done_early", pe_fd, 0);
    @(negedge clk);
    check("par_even_done", pe_fd, 1);
    check("par_odd_done", po_fd, 1);
    @(negedge clk);
    check("par_even_count", pe_fc, 1);
    check("par_odd_count", po_fc, 1);
    check("par_odd_busy", po_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
Read-side consumer of synchronous_fifo. It pops one word at a time from the FIFO and transmits it on a single-wire, UART-style serial line: start bit, data LSB-first, optional parity bit, stop bit. It sits directly downstream of the FIFO read port and drives that FIFO's rd_en.

Parameters:
DATA_WIDTH, 8, width of the FIFO word and of the serial data field
CLKS_PER_BIT, 4, clk cycles per serial bit; legal range is 2 or more
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  reset: one clock; reset is synchronous and active-high (rst_n=1 resets)
fifo_empty  input  1  FIFO empty flag
fifo_data_out  input  DATA_WIDTH  FIFO read data; valid the cycle after rd_en is sampled
fifo_rd_en  output  1  FIFO pop strobe; one cycle per word
tx_en  input  1  permits starting new frames
tx  output  1  serial line; idle level is 1
busy  output  1  high in every state except IDLE
frame_done  output  1  one-cycle pulse when a stop bit completes
frame_count  output  16  frames sent since reset; wraps from 0xFFFF to 0

Behaviour:
- All outputs are registered or Moore-decoded from registered state. None depend combinationally on inputs.
- Reset values: tx=1, fifo_rd_en=0, busy=0, frame_done=0, frame_count=0, state=IDLE, bit and baud counters=0.
- Reset has priority over every other event. Reset mid-frame aborts the frame, tx=1 on the next cycle, and the popped word is discarded.
- FSM states and transitions:
  - IDLE: tx=1. If tx_en && !fifo_empty, go to POP. Otherwise stay.
  - POP: exactly 1 cycle, fifo_rd_en=1, then LOAD.
  - LOAD: 1 cycle. Capture fifo_data_out into the shift register and compute parity (XOR of the data, inverted if PARITY_ODD). Then START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After DATA_WIDTH bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx=parity bit for CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. In the last cycle of STOP, frame_done=1 and frame_count increments. Then IDLE.
- The baud counter counts 0..CLKS_PER_BIT-1 and reloads to 0 on each bit boundary. The bit counter is $clog2(DATA_WIDTH+1) bits wide.
- Start latency: if the IDLE condition holds in cycle 0, POP is in cycle 1, LOAD in cycle 2, and tx first goes low in cycle 3.
- Frame length: tx is low at START onset, and the frame lasts (2+DATA_WIDTH+PARITY_EN)*CLKS_PER_BIT cycles from START onset to the end of STOP.
- Back-to-back frames: the gap between frames is IDLE+POP+LOAD, i.e. 3 cycles of tx=1 beyond the stop bit.
- fifo_rd_en never asserts while fifo_empty=1 in IDLE. fifo_empty and tx_en are ignored outside IDLE.
- Dropping tx_en mid-frame does not abort the current frame; it only blocks the next POP.
- frame_count wraps silently from 0xFFFF to 0x0000.

Test Plan:
1. Hold rst_n=1 for 3 cycles with fifo_empty=0 and tx_en=1 -> tx=1, fifo_rd_en=0, busy=0, frame_count=0 throughout.
2. Single word 0xA5, CLKS_PER_BIT=4, no parity -> one rd_en pulse. tx=0 starts 2 cycles after rd_en. Bits are 1,0,1,0,0,1,0,1 for 4 cycles each, then stop=1. frame_done pulses 40 cycles after tx first goes low minus 1. frame_count=1.
3. Parity on 0xA5 (four ones): PARITY_ODD=0 -> parity bit 0; PARITY_ODD=1 -> parity bit 1. Frame length is 44 cycles.
4. FIFO holds 0x01, 0x02, 0x03 with tx_en=1 -> exactly 3 rd_en pulses, 3 idle-high cycles between frames, frame_count=3. Once empty, no further rd_en.
5. Deassert tx_en during DATA of frame 1 with 2 words queued -> frame 1 completes, no second rd_en while tx_en=0. Re-asserting tx_en starts frame 2 at the latency in Behaviour.
6. Assert rst_n during DATA bit 3 -> the next cycle has tx=1, busy=0, frame_count=0, and no frame_done. Once rst_n is released with the FIFO non-empty, POP occurs in the following cycle.
